fetch_width_aggregator: RTL and testbench

- Converts a narrow word stream from an upstream FIFO (show-ahead, valid/dequeue handshake) into wide packets of up to FETCH_WIDTH words for a downstream receiver (full_n/enqueue handshake).
- The packet width is runtime-selectable from 1 to FETCH_WIDTH.
- Sits between a synchronous FIFO read port and a wide consumer.
- Sustains one word per cycle when neither side stalls.

---
 rtl/fetch_width_aggregator_pkg.sv | 11 +
 rtl/fetch_width_aggregator.sv | 115 +++++++++++
 tb/tb_fetch_width_aggregator.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_width_aggregator_pkg.sv
// Shared constants and helpers for the fetch width aggregator.
package fetch_width_aggregator_pkg;

   localparam int unsigned DEFAULT_FETCH_WIDTH = 2;

   // Width of a field that holds 0..fetch_width inclusive.
   function automatic int unsigned fw_bits(input int unsigned fetch_width);
      return 32'($clog2(fetch_width)) + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_width_aggregator.sv
// Packs a narrow show-ahead FIFO word stream into packets of 1..FETCH_WIDTH
// words, oldest word in slot 0, with a runtime-selectable packet width.
module fetch_width_aggregator
   import fetch_width_aggregator_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned FETCH_WIDTH = DEFAULT_FETCH_WIDTH,
   parameter int unsigned FW_BITS     = fw_bits(FETCH_WIDTH)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [DATA_WIDTH-1:0]             sender_data,
   input  logic                              sender_empty_n,
   output logic                              sender_deq,
   output logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
   input  logic                              receiver_full_n,
   output logic                              receiver_enq,
   input  logic                              change_fetch_width,
   input  logic [FW_BITS-1:0]                input_fetch_width
);

   logic [FW_BITS-1:0] count_q, count_d;
   logic [FW_BITS-1:0] fw_q, fw_d;
   logic [FW_BITS-1:0] fw_eff;
   logic [FW_BITS-1:0] idx;
   logic [FW_BITS-1:0] next_cnt;
   logic               full_q, full_d;
   logic               accept;
   logic               drain;
   logic               legal_change;
   logic               start;
   logic               clear;

   // Handshakes; both forced low while reset is held.
   assign drain        = rst_n & full_q & receiver_full_n;
   assign accept       = rst_n & sender_empty_n & (~full_q | receiver_full_n);
   assign receiver_enq = drain;
   assign sender_deq   = accept;

   assign legal_change = change_fetch_width
                       & (input_fetch_width >= FW_BITS'(1))
                       & (input_fetch_width <= FW_BITS'(FETCH_WIDTH));

   // A new packet begins at slot 0 after a drain, a width change, or from empty.
   assign start = legal_change | drain | (count_q == '0);

   // Partial packet is discarded on a width change unless a full packet is still held.
   assign clear = legal_change & ~accept & ~(full_q & ~drain);

   // Next-state for count, packet_full and fetch width.
   always_comb begin
      fw_eff   = legal_change ? input_fetch_width : fw_q;
      idx      = start ? '0 : count_q;
      next_cnt = idx + FW_BITS'(1);
      fw_d     = fw_eff;
      count_d  = count_q;
      full_d   = full_q & ~drain;
      if (accept) begin
         if (next_cnt == fw_eff) begin
            full_d  = 1'b1;
            count_d = '0;
         end else begin
            full_d  = 1'b0;
            count_d = next_cnt;
         end
      end else if (legal_change) begin
         count_d = '0;
      end
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         full_q  <= 1'b0;
         fw_q    <= FW_BITS'(FETCH_WIDTH);
      end else begin
         count_q <= count_d;
         full_q  <= full_d;
         fw_q    <= fw_d;
      end
   end

   // Per-slot packing buffer; the buffer drives receiver_data directly.
   for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
      logic [DATA_WIDTH-1:0] slot_q;
      logic [DATA_WIDTH-1:0] slot_d;

      // Slot 0 takes the first word of a new packet, other slots are wiped.
      always_comb begin
         slot_d = slot_q;
         if (accept) begin
            if (start) begin
               slot_d = (i == 0) ? sender_data : '0;
            end else if (count_q == FW_BITS'(i)) begin
               slot_d = sender_data;
            end
         end else if (clear) begin
            slot_d = '0;
         end
      end

      // Slot storage.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            slot_q <= '0;
         end else begin
            slot_q <= slot_d;
         end
      end

      assign receiver_data[i*DATA_WIDTH +: DATA_WIDTH] = slot_q;
   end

endmodule

// File: tb/tb_fetch_width_aggregator.sv
// Scoreboard bench for fetch_width_aggregator (DATA_WIDTH=8, FETCH_WIDTH=2).
module tb_fetch_width_aggregator;

   localparam int unsigned DW  = 8;
   localparam int unsigned FW  = 2;
   localparam int unsigned FWB = 2;

   logic              clk;
   logic              rst_n;
   logic [DW-1:0]     sender_data;
   logic              sender_empty_n;
   logic              sender_deq;
   logic [FW*DW-1:0]  receiver_data;
   logic              receiver_full_n;
   logic              receiver_enq;
   logic              change_fetch_width;
   logic [FWB-1:0]    input_fetch_width;

   int                tests;
   int                fails;
   int                deq_cnt;
   logic              deq_seen;
   logic              gate;
   logic [DW-1:0]     src_q[$];
   logic [FW*DW-1:0]  exp_q[$];

   fetch_width_aggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .sender_data        (sender_data),
      .sender_empty_n     (sender_empty_n),
      .sender_deq         (sender_deq),
      .receiver_data      (receiver_data),
      .receiver_full_n    (receiver_full_n),
      .receiver_enq       (receiver_enq),
      .change_fetch_width (change_fetch_width),
      .input_fetch_width  (input_fetch_width)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive the show-ahead head of the modelled upstream FIFO.
   task automatic refresh();
      sender_empty_n = gate && (src_q.size() != 0);
      sender_data    = (src_q.size() != 0) ? src_q[0] : '0;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_drain(input int budget);
      for (int c = 0; c < budget && exp_q.size() != 0; c++) step();
   endtask

   // Sample handshakes mid-cycle; score every transferred packet.
   always @(negedge clk) begin
      logic [FW*DW-1:0] e;
      deq_seen = sender_deq;
      if (rst_n && receiver_enq) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_packet: got %h, none expected", receiver_data);
         end else begin
            e = exp_q.pop_front();
            if (receiver_data !== e) begin
               fails++;
               $display("FAIL packet_data: got %h, expected %h", receiver_data, e);
            end
         end
      end
   end

   // Upstream FIFO pops the head after each cycle where sender_deq was high.
   always @(posedge clk) begin
      #1;
      if (deq_seen && src_q.size() != 0) begin
         void'(src_q.pop_front());
         deq_cnt++;
      end
      deq_seen = 1'b0;
      refresh();
   end

   task automatic test_reset();
      rst_n = 1'b0;
      gate = 1'b1;
      receiver_full_n = 1'b1;
      change_fetch_width = 1'b0;
      input_fetch_width = '0;
      src_q.push_back(8'hAA);
      refresh();
      #7;
      tests++;
      if (sender_deq !== 1'b0) begin fails++; $display("FAIL reset_deq: got %b, expected 0", sender_deq); end
      tests++;
      if (receiver_enq !== 1'b0) begin fails++; $display("FAIL reset_enq: got %b, expected 0", receiver_enq); end
      tests++;
      if (receiver_data !== '0) begin fails++; $display("FAIL reset_data: got %h, expected 0000", receiver_data); end
      src_q.delete();
      refresh();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_streaming();
      int d0;
      d0 = deq_cnt;
      for (int w = 0; w < 4; w++) src_q.push_back(DW'(w));
      exp_q.push_back(16'h0100);
      exp_q.push_back(16'h0302);
      refresh();
      wait_drain(40);
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL stream_timeout: %0d packets pending, expected 0", exp_q.size()); exp_q.delete(); end
      tests++;
      if (deq_cnt - d0 != 4) begin fails++; $display("FAIL stream_deq_count: got %0d, expected 4", deq_cnt - d0); end
   endtask

   task automatic test_random_gaps();
      int d0;
      d0 = deq_cnt;
      for (int k = 0; k < 100; k += 2) begin
         src_q.push_back(DW'(8'h10 + k));
         src_q.push_back(DW'(8'h10 + k + 1));
         exp_q.push_back({DW'(8'h10 + k + 1), DW'(8'h10 + k)});
      end
      for (int c = 0; c < 200; c++) begin
         step();
         gate = 1'($urandom_range(0, 1));
         refresh();
      end
      gate = 1'b1;
      refresh();
      wait_drain(300);
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL gaps_timeout: %0d packets pending, expected 0", exp_q.size()); exp_q.delete(); end
      tests++;
      if (deq_cnt - d0 != 100) begin fails++; $display("FAIL gaps_deq_count: got %0d, expected 100", deq_cnt - d0); end
   endtask

   task automatic test_backpressure();
      receiver_full_n = 1'b0;
      for (int w = 0; w < 4; w++) src_q.push_back(DW'(w));
      exp_q.push_back(16'h0100);
      exp_q.push_back(16'h0302);
      refresh();
      repeat (3) step();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests++;
         if (receiver_enq !== 1'b0) begin fails++; $display("FAIL bp_enq: got %b, expected 0", receiver_enq); end
         tests++;
         if (receiver_data !== 16'h0100) begin fails++; $display("FAIL bp_data: got %h, expected 0100", receiver_data); end
         tests++;
         if (sender_deq !== 1'b0) begin fails++; $display("FAIL bp_deq: got %b, expected 0", sender_deq); end
      end
      step();
      receiver_full_n = 1'b1;
      @(negedge clk);
      tests++;
      if (receiver_enq !== 1'b1) begin fails++; $display("FAIL bp_release: got %b, expected 1", receiver_enq); end
      wait_drain(40);
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL bp_timeout: %0d packets pending, expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_width_change();
      // Width 1: each word is its own packet.
      step(); change_fetch_width = 1'b1; input_fetch_width = 2'd1;
      step(); change_fetch_width = 1'b0;
      src_q.push_back(8'h04); src_q.push_back(8'h05);
      exp_q.push_back(16'h0004); exp_q.push_back(16'h0005);
      refresh();
      wait_drain(40);
      // Back to width 2, then drop a lone pending word with another change.
      step(); change_fetch_width = 1'b1; input_fetch_width = 2'd2;
      step(); change_fetch_width = 1'b0;
      src_q.push_back(8'h06); refresh();
      repeat (3) step();
      change_fetch_width = 1'b1; input_fetch_width = 2'd2;
      step(); change_fetch_width = 1'b0;
      src_q.push_back(8'h07); src_q.push_back(8'h08);
      exp_q.push_back(16'h0807);
      refresh();
      wait_drain(40);
      // Out-of-range requests leave width and partial packet intact.
      src_q.push_back(8'h09); refresh();
      repeat (3) step();
      change_fetch_width = 1'b1; input_fetch_width = 2'd0;
      step(); change_fetch_width = 1'b0;
      src_q.push_back(8'h0A); exp_q.push_back(16'h0A09); refresh();
      wait_drain(40);
      src_q.push_back(8'h0B); refresh();
      repeat (3) step();
      change_fetch_width = 1'b1; input_fetch_width = 2'd3;
      step(); change_fetch_width = 1'b0;
      src_q.push_back(8'h0C); exp_q.push_back(16'h0C0B); refresh();
      wait_drain(40);
      // Word accepted with the change starts the new packet at slot 0.
      src_q.push_back(8'h0D); refresh();
      repeat (3) step();
      change_fetch_width = 1'b1; input_fetch_width = 2'd2;
      src_q.push_back(8'h0E); refresh();
      step(); change_fetch_width = 1'b0;
      src_q.push_back(8'h0F); exp_q.push_back(16'h0F0E); refresh();
      wait_drain(40);
      repeat (3) step();
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL width_timeout: %0d packets pending, expected 0", exp_q.size()); exp_q.delete(); end
      tests++;
      if (src_q.size() != 0) begin fails++; $display("FAIL width_src_left: %0d words left, expected 0", src_q.size()); src_q.delete(); refresh(); end
   endtask

   task automatic test_reset_mid();
      src_q.push_back(8'h20); refresh();
      step();
      src_q.push_back(8'h21); refresh();
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if (sender_deq !== 1'b0) begin fails++; $display("FAIL mid_reset_deq: got %b, expected 0", sender_deq); end
      tests++;
      if (receiver_enq !== 1'b0) begin fails++; $display("FAIL mid_reset_enq: got %b, expected 0", receiver_enq); end
      tests++;
      if (receiver_data !== '0) begin fails++; $display("FAIL mid_reset_data: got %h, expected 0000", receiver_data); end
      src_q.push_back(8'h22);
      exp_q.push_back(16'h2221);
      refresh();
      step(); step();
      rst_n = 1'b1;
      wait_drain(40);
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL mid_reset_timeout: %0d packets pending, expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      deq_cnt = 0;
      deq_seen = 1'b0;
      gate = 1'b1;
      sender_data = '0;
      sender_empty_n = 1'b0;
      receiver_full_n = 1'b1;
      change_fetch_width = 1'b0;
      input_fetch_width = '0;
      rst_n = 1'b0;
      test_reset();
      test_streaming();
      test_random_gaps();
      test_backpressure();
      test_width_change();
      test_reset_mid();
      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
